// File: rtl/gb_flash_reader.sv
// SPI NOR word reader: 0x03 + 24-bit address, four data bytes returned little-endian.
// Define GB_FLASH_WAKEUP_EN to send 0xAB (release power-down) and wait WAKE_WAIT cycles after reset.
module gb_flash_reader #(
  parameter int CLK_DIV   = 1,
  parameter int WAKE_WAIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [23:0] addr,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_MAX = (WAKE_WAIT > 2 * CLK_DIV) ? WAKE_WAIT : 2 * CLK_DIV;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] DONE_LAST = WAIT_W'(2 * CLK_DIV - 1);

`ifdef GB_FLASH_WAKEUP_EN
  typedef enum logic [2:0] {WAKE, WAKE_GAP, IDLE, XFER, DONE} state_t;
  localparam state_t RESET_STATE = WAKE;
  localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'(WAKE_WAIT);
`else
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [5:0]        bit_q, bit_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [30:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              csn_q, csn_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic              shifting;
  logic [5:0]        bit_last;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    wait_d   = wait_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    csn_d    = csn_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    ready_d  = 1'b0;
    shifting = 1'b0;
    bit_last = 6'd63;

    case (state_q)
      IDLE: begin
        if (valid) begin
          // tx holds the 31 bits after the first; the first bit of 0x03 is 0
          state_d = XFER;
          csn_d   = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = 1'b0;
          tx_d    = {7'h03, addr};
          div_d   = '0;
          bit_d   = '0;
        end
      end
      XFER: shifting = 1'b1;
      DONE: begin
        if (wait_q == DONE_LAST) state_d = IDLE;
        else wait_d = wait_q + WAIT_W'(1);
      end
`ifdef GB_FLASH_WAKEUP_EN
      WAKE: begin
        if (csn_q) begin
          csn_d  = 1'b0;
          sck_d  = 1'b0;
          mosi_d = 1'b1;
          tx_d   = {7'h2B, 24'h0};
          div_d  = '0;
          bit_d  = '0;
        end else begin
          shifting = 1'b1;
          bit_last = 6'd7;
        end
      end
      WAKE_GAP: begin
        if (wait_q == GAP_LAST) state_d = IDLE;
        else wait_d = wait_q + WAIT_W'(1);
      end
`endif
      default: state_d = RESET_STATE;
    endcase

    // Shared bit engine: MISO sampled as SCK rises, MOSI advanced as SCK falls
    if (shifting) begin
      if (div_q != DIV_LAST) begin
        div_d = div_q + DIV_W'(1);
      end else begin
        div_d = '0;
        sck_d = ~sck_q;
        if (!sck_q) begin
          rx_d = {rx_q[30:0], spi_miso};
        end else if (bit_q == bit_last) begin
          sck_d   = 1'b0;
          csn_d   = 1'b1;
          mosi_d  = 1'b0;
          wait_d  = WAIT_W'(1);
          state_d = DONE;
          ready_d = 1'b1;
          rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
`ifdef GB_FLASH_WAKEUP_EN
          if (state_q == WAKE) begin
            state_d = WAKE_GAP;
            ready_d = 1'b0;
            rdata_d = rdata_q;
          end
`endif
        end else begin
          bit_d  = bit_q + 6'd1;
          mosi_d = tx_q[30];
          tx_d   = {tx_q[29:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      div_q   <= '0;
      bit_q   <= '0;
      wait_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      csn_q   <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      wait_q  <= wait_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      csn_q   <= csn_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign rdata    = rdata_q;
  assign spi_csn  = csn_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
endmodule

// File: tb/tb_gb_flash_reader.sv
// Bench for gb_flash_reader: SPI flash model on a CLK_DIV=1 instance, timing checks on a CLK_DIV=3 instance.
module tb_gb_flash_reader;
  localparam int DIV_B = 3;

  typedef struct {
    int          pulses;
    logic [63:0] bits;
    int          gap;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_a, ready_a, csn_a, sck_a, mosi_a;
  logic        miso_a = 1'b0;
  logic [23:0] addr_a;
  logic [31:0] rdata_a;
  logic        valid_b, ready_b, csn_b, sck_b, mosi_b;
  logic        miso_b = 1'b1;
  logic [23:0] addr_b;
  logic [31:0] rdata_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gb_flash_reader #(.CLK_DIV(1), .WAKE_WAIT(64)) u_dut_a (
    .clk(clk), .reset(reset), .valid(valid_a), .addr(addr_a), .ready(ready_a), .rdata(rdata_a),
    .spi_csn(csn_a), .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  gb_flash_reader #(.CLK_DIV(DIV_B), .WAKE_WAIT(64)) u_dut_b (
    .clk(clk), .reset(reset), .valid(valid_b), .addr(addr_b), .ready(ready_b), .rdata(rdata_b),
    .spi_csn(csn_b), .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  function automatic logic [7:0] byte_at(input logic [23:0] a);
    case (a)
      24'h100000: return 8'h11;
      24'h100001: return 8'h22;
      24'h100002: return 8'h33;
      24'h100003: return 8'h44;
      default:    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {byte_at(a + 24'd3), byte_at(a + 24'd2), byte_at(a + 24'd1), byte_at(a)};
  endfunction

  // Flash model on instance A: records each CSN-low frame, serves bytes after 32 command bits
  frame_t      frames[$];
  bit          fa_active = 1'b0;
  int          fa_pulses = 0;
  logic [63:0] fa_bits   = '0;
  logic [23:0] fa_addr   = '0;
  int          fa_gap    = 0;
  int          hi_run    = 0;
  int          rdy_cnt_a = 0;
  int          viol      = 0;

  always @(posedge sck_a) begin
    if (csn_a === 1'b0) begin
      fa_bits = {fa_bits[62:0], mosi_a};
      fa_pulses++;
      if (fa_pulses == 32) fa_addr = fa_bits[23:0];
    end
  end

  always @(negedge sck_a) begin
    if (csn_a === 1'b0 && fa_pulses >= 32 && fa_pulses < 64) begin
      int d;
      logic [7:0] b;
      d = fa_pulses - 32;
      b = byte_at(fa_addr + 24'(d / 8));
      miso_a = b[7 - (d % 8)];
    end else begin
      miso_a = 1'b0;
    end
  end

  always @(negedge csn_a) begin
    fa_active = 1'b1;
    fa_pulses = 0;
    fa_bits   = '0;
    fa_gap    = hi_run;
    miso_a    = 1'b0;
  end

  always @(posedge csn_a) begin
    if (fa_active) begin
      frame_t f;
      f.pulses = fa_pulses;
      f.bits   = fa_bits;
      f.gap    = fa_gap;
      frames.push_back(f);
      fa_active = 1'b0;
    end
  end

  // SCK phase lengths on instance B
  int hi_b = 0;
  int bad_run_b = 0;
  int run_b = 0;
  bit prev_low_b = 1'b0;
  logic prev_sck_b = 1'b0;

  always @(negedge clk) begin
    if (csn_a === 1'b1) hi_run++;
    else hi_run = 0;
    if (ready_a === 1'b1) rdy_cnt_a++;
    if (csn_a === 1'b1 && (sck_a !== 1'b0 || mosi_a !== 1'b0)) viol++;
    if (csn_b === 1'b1 && (sck_b !== 1'b0 || mosi_b !== 1'b0)) viol++;
    if (csn_b === 1'b0) begin
      if (prev_low_b && sck_b === prev_sck_b) run_b++;
      else begin
        if (prev_low_b && run_b != DIV_B) bad_run_b++;
        run_b = 1;
      end
      if (sck_b === 1'b1) hi_b++;
    end
    prev_low_b = (csn_b === 1'b0);
    prev_sck_b = sck_b;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_ready(input bit use_b, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((use_b ? ready_b : ready_a) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic check_frame(input logic [23:0] a, input string tag, output int gap);
    frame_t f;
    gap = -1;
    chk({tag, "_frame_seen"}, 64'(frames.size() != 0), 64'd1);
    if (frames.size() != 0) begin
      f = frames.pop_front();
      gap = f.gap;
      chk({tag, "_pulses"}, 64'(f.pulses), 64'd64);
      chk({tag, "_mosi"}, f.bits, {8'h03, a, 32'h0});
    end
  endtask

  task automatic read_a(input logic [23:0] a, input int drop_after, input string tag);
    int t, at, r0, g;
    r0 = rdy_cnt_a;
    @(negedge clk);
    valid_a = 1'b1;
    addr_a  = a;
    t = cyc;
    if (drop_after > 0) begin
      repeat (drop_after) @(negedge clk);
      valid_a = 1'b0;
      addr_a  = ~a;
    end
    wait_ready(1'b0, 1000, at);
    valid_a = 1'b0;
    chk({tag, "_latency"}, 64'(at - t), 64'd129);
    chk({tag, "_rdata"}, 64'(rdata_a), 64'(exp_word(a)));
    check_frame(a, tag, g);
    repeat (4) @(negedge clk);
    chk({tag, "_nready"}, 64'(rdy_cnt_a - r0), 64'd1);
  endtask

  initial begin
    int at, t, g, r0;
    int rdy_at[4];
    logic [23:0] ra;
    frame_t f;

    reset = 1'b1;
    valid_a = 1'b0; addr_a = '0;
    valid_b = 1'b0; addr_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_csn", 64'(csn_a), 64'd1);
    chk("rst_sck", 64'(sck_a), 64'd0);
    chk("rst_mosi", 64'(mosi_a), 64'd0);
    chk("rst_ready", 64'(ready_a), 64'd0);
    chk("rst_rdata", 64'(rdata_a), 64'd0);
    chk("rst_csn_b", 64'(csn_b), 64'd1);

    reset = 1'b0;
    @(posedge clk); #1;
    chk("csn_after_release", 64'(csn_a), 64'd1);

    // First read right after reset; with wake-up enabled it must wait behind the 0xAB frame
    @(negedge clk);
    valid_a = 1'b1;
    addr_a  = 24'h100000;
    wait_ready(1'b0, 1000, at);
    valid_a = 1'b0;
    @(negedge clk);
    chk("boot_seen", 64'(at != -1), 64'd1);
    chk("boot_rdata", 64'(rdata_a), 64'h44332211);
    chk("boot_nready", 64'(rdy_cnt_a), 64'd1);
`ifdef GB_FLASH_WAKEUP_EN
    chk("wake_nframes", 64'(frames.size()), 64'd2);
    if (frames.size() != 0) begin
      f = frames.pop_front();
      chk("wake_pulses", 64'(f.pulses), 64'd8);
      chk("wake_cmd", f.bits, 64'hAB);
    end
    check_frame(24'h100000, "boot", g);
    chk("wake_gap_min", 64'(g >= 64), 64'd1);
`else
    chk("boot_nframes", 64'(frames.size()), 64'd1);
    check_frame(24'h100000, "boot", g);
`endif
    repeat (200) @(negedge clk);
    frames.delete();

    read_a(24'h100000, 0, "word0");
    chk("word0_literal", 64'(rdata_a), 64'h44332211);
    read_a(24'hFFFFFF, 0, "addr_top");
    for (int i = 0; i < 3; i++) read_a(24'($urandom), 0, "rand");

    // Back-to-back: valid held, address advanced in each ready cycle
    r0 = rdy_cnt_a;
    @(negedge clk);
    valid_a = 1'b1;
    addr_a  = 24'h100000;
    for (int i = 0; i < 4; i++) begin
      wait_ready(1'b0, 1000, at);
      rdy_at[i] = at;
      chk("b2b_rdata", 64'(rdata_a), 64'(exp_word(24'h100000 + 24'(4 * i))));
      addr_a = 24'h100000 + 24'(4 * (i + 1));
    end
    valid_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_nready", 64'(rdy_cnt_a - r0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_frame(24'h100000 + 24'(4 * i), "b2b", g);
      if (i > 0) begin
        chk("b2b_csn_gap", 64'(g), 64'd2);
        chk("b2b_spacing", 64'(rdy_at[i] - rdy_at[i-1]), 64'd130);
      end
    end

    // Reset in the middle of a frame
    r0 = rdy_cnt_a;
    ra = 24'($urandom);
    @(negedge clk);
    valid_a = 1'b1;
    addr_a  = ra;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (fa_pulses >= 20) break;
    end
    reset = 1'b1;
    #1;
    chk("midrst_csn", 64'(csn_a), 64'd1);
    chk("midrst_sck", 64'(sck_a), 64'd0);
    chk("midrst_mosi", 64'(mosi_a), 64'd0);
    chk("midrst_rdata", 64'(rdata_a), 64'd0);
    valid_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_ready", 64'(rdy_cnt_a - r0), 64'd0);
    chk("midrst_nframes", 64'(frames.size()), 64'd1);
    if (frames.size() != 0) chk("midrst_pulses", 64'(frames[0].pulses), 64'd20);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    frames.delete();
    read_a(ra, 0, "post_rst");

    // valid dropped and addr changed mid-frame
    read_a(24'h100000 + 24'($urandom_range(0, 255)), 10, "drop");

    // Slow SCK instance
    hi_b = 0;
    bad_run_b = 0;
    @(negedge clk);
    valid_b = 1'b1;
    addr_b  = 24'($urandom);
    t = cyc;
    wait_ready(1'b1, 2000, at);
    valid_b = 1'b0;
    chk("div3_latency", 64'(at - t), 64'd385);
    chk("div3_rdata", 64'(rdata_b), 64'hFFFF_FFFF);
    chk("div3_sck_high_cycles", 64'(hi_b), 64'd192);
    chk("div3_bad_phase", 64'(bad_run_b), 64'd0);

    repeat (4) @(negedge clk);
    chk("csn_idle_quiet", 64'(viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gb_flash_reader.md
GB_FLASH_READER -- requirements
Module: gb_flash_reader

Interface
REQ-001 Parameter CLK_DIV, default 1, clk cycles per SCK half-period (legal 1..15).
REQ-002 Parameter WAKE_WAIT, default 64, clk cycles CSN held high after the wake-up command.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 valid  input  1  read request; held high by requester until ready.
REQ-006 addr  input  24  flash byte address of the 32-bit word to read.
REQ-007 ready  output  1  one-cycle pulse: rdata valid, request complete.
REQ-008 rdata  output  32  read word, little-endian (first flash byte in [7:0]).
REQ-009 spi_csn  output  1  flash chip select, active-low.
REQ-010 spi_sck  output  1  SPI clock, mode 0 (idle low).
REQ-011 spi_mosi  output  1  serial data to flash, MSB first.
REQ-012 spi_miso  input  1  serial data from flash.

Function
REQ-013 States: WAKE, WAKE_GAP, IDLE, XFER, DONE; exit from reset enters WAKE (macro set) or IDLE (macro clear).
REQ-014 IDLE: valid sampled high at cycle T -> addr latched, 64-bit frame counter cleared, state XFER, spi_csn low from T+1.
REQ-015 XFER bit timing: SCK low CLK_DIV cycles then high CLK_DIV cycles; MOSI updated only while SCK low; MISO sampled on the clk edge that raises SCK.
REQ-016 XFER frame: bits 0-7 = 0x03, bits 8-31 = latched addr MSB first, bits 32-63 = data; MOSI driven 0 during data bits.
REQ-017 Data bytes assembled MSB-first per byte; byte n (0..3) lands in rdata[8n+7:8n].
REQ-018 After the 64th SCK high phase: SCK low, spi_csn high, state DONE; ready high exactly at cycle T+1+128*CLK_DIV, for one cycle.
REQ-019 rdata updated only in the ready cycle; held stable until the next ready.
REQ-020 DONE -> IDLE after spi_csn has been high 2*CLK_DIV cycles (inclusive of ready cycle); valid is not sampled before IDLE.
REQ-021 valid high in the first IDLE cycle after DONE starts a new frame (back-to-back loader reads), new addr latched.
REQ-022 valid dropped mid-frame: frame completes, ready still pulses once; no abort.
REQ-023 addr changes mid-frame ignored; only the value latched at T is used.
REQ-024 addr wrap: 0xFFFFFF sent unmodified; flash-side wrap not handled here.
REQ-025 spi_sck low and spi_mosi 0 whenever spi_csn high.

Reset
REQ-026 reset high -> immediately: spi_csn 1, spi_sck 0, spi_mosi 0, ready 0, rdata 0, counters 0.
REQ-027 reset mid-frame aborts the frame with no ready pulse; after release the block restarts per REQ-013, including wake-up if enabled.
REQ-028 No output glitches low on spi_csn during reset assertion or the first cycle after release.

Configuration
REQ-029 Macro GB_FLASH_WAKEUP_EN defined: WAKE sends one 8-bit frame 0xAB (same timing as REQ-015), then WAKE_GAP holds spi_csn high WAKE_WAIT cycles, then IDLE; valid ignored (ready 0) until IDLE.
REQ-030 Macro GB_FLASH_WAKEUP_EN undefined: WAKE and WAKE_GAP logic absent; reset exits directly to IDLE; WAKE_WAIT unused.

Verification
REQ-031 Flash model bytes 0x100000..0x100003 = 11 22 33 44, CLK_DIV=1, valid with addr 0x100000 -> MOSI 03 10 00 00, 64 SCK pulses, ready at T+129, rdata 0x44332211.
REQ-032 Macro defined, reset released -> first CSN-low frame has 8 SCK pulses carrying 0xAB, CSN high >= 64 cycles, then first read frame; ready stays 0 throughout wake.
REQ-033 CLK_DIV=3, single read -> SCK high/low phases 3 cycles each, ready at T+385.
REQ-034 valid held high for 4 words at 0x100000/4/8/C -> 4 ready pulses, CSN high exactly 2 cycles between frames, rdata matches model each pulse.
REQ-035 reset asserted at SCK pulse 20 -> CSN high same cycle, no ready; after release, next read returns correct word.
REQ-036 valid dropped after 10 cycles, addr toggled mid-frame -> frame completes on original addr, single ready pulse.
